// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: ready/valid front end that drives one SRAM column's real word/bit lines and senses reads.
// Optional build macro WR_VERIFY_EN: each write is followed by a checked read-back of the same row.
module sram_rw_ctrl #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned AW     = $clog2(ROWS),
  parameter int unsigned WR_CYC = 2,
  parameter int unsigned RD_CYC = 2,
  parameter real         VDD    = 1.5,
  parameter real         VSS    = 0.0,
  parameter real         VTH    = 0.8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic          req_wdata,
  output logic          rvalid,
  output logic          rdata,
  output logic          err,
  output real           row_wr [ROWS],
  output real           row_rd [ROWS],
  output real           bl_wr,
  output real           blb_wr,
  input  real           bl_rd  [ROWS],
  input  real           blb_rd [ROWS]
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrSetup = 3'd1;
  localparam logic [2:0] StWrPulse = 3'd2;
  localparam logic [2:0] StWrHold  = 3'd3;
  localparam logic [2:0] StRdPulse = 3'd4;
  localparam logic [2:0] StRdDone  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic          wdata_q, wdata_d;
  logic          rdata_q, rdata_d;
  logic          err_q, err_d;

  real  sel_bl, sel_blb;
  logic addr_ok, sense_ok, sense_bit;

  // An out-of-range row matches nothing, so it senses as invalid and drives no word line.
  always_comb begin
    sel_bl  = VSS;
    sel_blb = VSS;
    addr_ok = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (addr_q == AW'(i)) begin
        sel_bl  = bl_rd[i];
        sel_blb = blb_rd[i];
        addr_ok = 1'b1;
      end
    end
    sense_ok  = addr_ok && ((sel_bl >= VTH) != (sel_blb >= VTH));
    sense_bit = sense_ok && (sel_bl >= VTH);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = req_we ? StWrSetup : StRdPulse;
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: begin
        if (cnt_q == 8'(WR_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef WR_VERIFY_EN
      StWrHold: state_d = StRdPulse;
`else
      StWrHold: state_d = StIdle;
`endif
      StRdPulse: begin
        if (cnt_q == 8'(RD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StRdDone;
          rdata_d = sense_bit;
          // we_q is only set here on a write read-back, where the sensed bit must match.
          err_d   = !sense_ok || (we_q && (sense_bit != wdata_q));
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 1'b0;
      rdata_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rvalid    = (state_q == StRdDone);
  assign rdata     = rdata_q;
  assign err       = rvalid && err_q;

  // Lines decode purely from registered state so an async reset drops them at once.
  always_comb begin
    bl_wr  = VSS;
    blb_wr = VSS;
    if (state_q == StWrSetup || state_q == StWrPulse || state_q == StWrHold) begin
      bl_wr  = wdata_q ? VDD : VSS;
      blb_wr = wdata_q ? VSS : VDD;
    end
    for (int i = 0; i < ROWS; i++) begin
      row_wr[i] = VSS;
      row_rd[i] = VSS;
      if (addr_q == AW'(i)) begin
        if (state_q == StWrPulse) row_wr[i] = VDD;
        if (state_q == StRdPulse) row_rd[i] = VDD;
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Testbench for sram_rw_ctrl: behavioural cell column model, vector table, scoreboard of read results.
module tb_sram_rw_ctrl;
  localparam int unsigned ROWS   = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned WR_CYC = 2;
  localparam int unsigned RD_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we, req_wdata, rvalid, rdata, err;
  logic [AW-1:0] req_addr;
  real           row_wr [ROWS];
  real           row_rd [ROWS];
  real           bl_rd  [ROWS];
  real           blb_rd [ROWS];
  real           bl_wr, blb_wr;

  // Second instance with a non-power-of-two column for out-of-range checks.
  logic       v6, r6_ready, we6, wd6, r6_rvalid, r6_rdata, r6_err;
  logic [2:0] a6;
  real        row_wr6 [6];
  real        row_rd6 [6];
  real        bl_rd6  [6];
  real        blb_rd6 [6];
  real        bl_wr6, blb_wr6;

  sram_rw_ctrl #(.ROWS(ROWS), .AW(AW), .WR_CYC(WR_CYC), .RD_CYC(RD_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rvalid(rvalid), .rdata(rdata), .err(err),
    .row_wr(row_wr), .row_rd(row_rd), .bl_wr(bl_wr), .blb_wr(blb_wr), .bl_rd(bl_rd),
    .blb_rd(blb_rd)
  );

  sram_rw_ctrl #(.ROWS(6), .AW(3), .WR_CYC(WR_CYC), .RD_CYC(RD_CYC)) dut6 (
    .clk(clk), .rst(rst), .req_valid(v6), .req_ready(r6_ready), .req_we(we6),
    .req_addr(a6), .req_wdata(wd6), .rvalid(r6_rvalid), .rdata(r6_rdata), .err(r6_err),
    .row_wr(row_wr6), .row_rd(row_rd6), .bl_wr(bl_wr6), .blb_wr(blb_wr6), .bl_rd(bl_rd6),
    .blb_rd(blb_rd6)
  );

  // Cell model: stores on a high write word line; bad[] drives both bitlines high,
  // force_lo[] pulls the true bitline low.
  logic mem      [ROWS];
  logic bad      [ROWS];
  logic force_lo [ROWS];

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      bl_rd[i]  = (bad[i] || (mem[i] && !force_lo[i])) ? 1.5 : 0.0;
      blb_rd[i] = (bad[i] || !mem[i]) ? 1.5 : 0.0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (rst) mem[i] <= 1'b0;
      else if (row_wr[i] > 0.75) mem[i] <= (bl_wr > 0.75) && (blb_wr < 0.75);
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  typedef struct {
    logic        rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic          wdata;
    logic          exp_rdata;
    logic          exp_err;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  function automatic logic lines_low();
    logic ok = 1'b1;
    for (int i = 0; i < ROWS; i++) if (row_wr[i] != 0.0 || row_rd[i] != 0.0) ok = 1'b0;
    if (bl_wr != 0.0 || blb_wr != 0.0) ok = 1'b0;
    return ok;
  endfunction

  // Monitor: at most one word line up, err only with rvalid, rvalid matched to the scoreboard.
  always @(negedge clk) begin
    int   nhigh;
    exp_t e;
    if (!rst) begin
      nhigh = 0;
      for (int i = 0; i < ROWS; i++) begin
        if (row_wr[i] > 0.0) nhigh++;
        if (row_rd[i] > 0.0) nhigh++;
      end
      chk("one_wordline", (nhigh <= 1) ? 1 : 0, 1);
      if (rvalid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", err, e.err);
          chk("rvalid_cycle", cyc, e.cyc);
        end
      end else begin
        chk("err_without_rvalid", err, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic d, input logic expv,
                       input logic er, input logic ee, input int unsigned lat);
    int unsigned n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: got req_ready=0 after %0d cycles expected 1", n);
    end else begin
      if (expv) sb.push_back('{er, ee, cyc + 1 + lat});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
  endtask

  initial begin
    logic        expv, seen, got_d, got_e, ok6;
    int unsigned lat, acc;

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 1'b0;
    v6 = 1'b0; we6 = 1'b0; a6 = '0; wd6 = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      bad[i]      = 1'b0;
      force_lo[i] = 1'b0;
    end
    bad[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bl_rd6[i]  = 1.5;
      blb_rd6[i] = 0.0;
    end

    rst = 1'b1;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_err", err, 0);
    chk("reset_lines", lines_low(), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write 1 to row 3, following every phase of the line sequencing.
    expv = 1'b0;
    lat  = 0;
`ifdef WR_VERIFY_EN
    expv = 1'b1;
    lat  = WR_CYC + RD_CYC + 2;
`endif
    acc = cyc + 1;
    issue(1'b1, 3'd3, 1'b1, expv, 1'b1, 1'b0, lat);
    req_valid = 1'b0;
    chk("setup_ready", req_ready, 0);
    chk_r("setup_bl", bl_wr, 1.5);
    chk_r("setup_blb", blb_wr, 0.0);
    chk_r("setup_row", row_wr[3], 0.0);
    for (int k = 0; k < WR_CYC; k++) begin
      @(negedge clk);
      chk_r("pulse_row", row_wr[3], 1.5);
      chk_r("pulse_bl", bl_wr, 1.5);
      chk_r("pulse_blb", blb_wr, 0.0);
    end
    @(negedge clk);
    chk_r("hold_row", row_wr[3], 0.0);
    chk_r("hold_bl", bl_wr, 1.5);
    chk("hold_ready", req_ready, 0);
`ifndef WR_VERIFY_EN
    @(negedge clk);
    chk("wr_latency_cycle", cyc, acc + WR_CYC + 2);
    chk("wr_done_ready", req_ready, 1);
    chk_r("wr_done_bl", bl_wr, 0.0);
`endif
    wait_drain();

    // Back-to-back table: req_valid stays high across the whole run.
    vecs[0]  = '{1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd7, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd6, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      expv = !vecs[i].we;
      lat  = RD_CYC;
`ifdef WR_VERIFY_EN
      if (vecs[i].we) begin
        expv = 1'b1;
        lat  = WR_CYC + RD_CYC + 2;
      end
`endif
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, expv, vecs[i].exp_rdata, vecs[i].exp_err,
            lat);
    end
    req_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a write pulse.
    issue(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk_r("midwr_pulse_row", row_wr[5], 1.5);
    rst = 1'b1;
    #1;
    chk("midwr_lines_low", lines_low(), 1);
    chk("midwr_ready_in_reset", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midwr_ready_after", req_ready, 1);
    chk("midwr_sb_empty", sb.size(), 0);

`ifdef WR_VERIFY_EN
    // Read-back sees the true bitline forced low: invalid sense, err with rdata 0.
    force_lo[2] = 1'b1;
    issue(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, WR_CYC + RD_CYC + 2);
    req_valid = 1'b0;
    wait_drain();
    force_lo[2] = 1'b0;
`endif

    // Six-row column, read row 7 while every real row offers a valid 1.
    chk("r6_ready", r6_ready, 1);
    v6 = 1'b1;
    we6 = 1'b0;
    a6 = 3'd7;
    @(posedge clk);
    @(negedge clk);
    v6 = 1'b0;
    ok6 = 1'b1;
    seen = 1'b0;
    got_d = 1'b1;
    got_e = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 6; i++) if (row_wr6[i] != 0.0 || row_rd6[i] != 0.0) ok6 = 1'b0;
      if (r6_rvalid && !seen) begin
        seen  = 1'b1;
        got_d = r6_rdata;
        got_e = r6_err;
      end
      @(negedge clk);
    end
    chk("oob_lines_low", ok6, 1);
    chk("oob_rvalid", seen, 1);
    chk("oob_rdata", got_d, 0);
    chk("oob_err", got_e, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
